// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio channel bank.
package audio_pkg;

  // Per-voice configuration field selector; codes 10..15 are ignored.
  typedef enum logic [3:0] {
    START_ADDR   = 4'd0,
    SAMPLE_COUNT = 4'd1,
    LOOP_START   = 4'd2,
    LOOP_END     = 4'd3,
    POSITION     = 4'd4,
    LAST_SAMPLE  = 4'd5,
    VOLUME       = 4'd6,
    LOOPING      = 4'd7,
    PLAYING      = 4'd8,
    ROUTE        = 4'd9
  } channel_field_t;

  // Output routing per voice; both 2 and 3 feed both sides.
  typedef enum logic [1:0] {
    ROUTE_LEFT     = 2'd0,
    ROUTE_RIGHT    = 2'd1,
    ROUTE_BOTH     = 2'd2,
    ROUTE_BOTH_ALT = 2'd3
  } route_t;

  // Sweep sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_FETCH  = 3'd2,
    ST_UPDATE = 3'd3,
    ST_NEXT   = 3'd4,
    ST_DONE   = 3'd5
  } bank_state_t;

  // Clamp a sign-extended value into the signed range of 'width' bits.
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] value,
                                               input int unsigned width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 32'd1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 32'd1));
    if (value > max_v) begin
      sat_s = max_v;
    end else if (value < min_v) begin
      sat_s = min_v;
    end else begin
      sat_s = value;
    end
  endfunction

endpackage

// File: rtl/delta_decoder.sv
// Combinational delta decode with saturation and loop/stop rules for one voice.
module delta_decoder
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int DELTA_W  = 12,
  parameter int POS_W    = 24
) (
  input  logic signed [SAMPLE_W-1:0] last_sample,
  input  logic signed [DELTA_W-1:0]  delta,
  input  logic [POS_W-1:0]           position,
  input  logic [POS_W-1:0]           sample_count,
  input  logic [POS_W-1:0]           loop_start,
  input  logic [POS_W-1:0]           loop_end,
  input  logic signed [SAMPLE_W-1:0] loop_start_sample,
  input  logic                       looping,
  input  logic                       playing,
  output logic signed [SAMPLE_W-1:0] next_sample,
  output logic [POS_W-1:0]           next_position,
  output logic                       next_playing,
  output logic signed [SAMPLE_W-1:0] next_loop_start_sample
);

  logic signed [63:0] ext_last_s;
  logic signed [63:0] ext_delta_s;
  logic signed [63:0] sum_s;
  logic signed [63:0] clamped_s;
  logic signed [SAMPLE_W-1:0] decoded_s;
  logic [POS_W:0] p1_s;

  // Decode the delta, then choose between loop wrap, end-of-sample stop and advance.
  always_comb begin
    ext_last_s  = {{(64-SAMPLE_W){last_sample[SAMPLE_W-1]}}, last_sample};
    ext_delta_s = {{(64-DELTA_W){delta[DELTA_W-1]}}, delta};
    sum_s       = ext_last_s + (ext_delta_s <<< 1);
    clamped_s   = sat_s(sum_s, SAMPLE_W);
    decoded_s   = clamped_s[SAMPLE_W-1:0];
    p1_s        = {1'b0, position} + {{POS_W{1'b0}}, 1'b1};
    next_playing = playing;
    if (looping && (p1_s >= {1'b0, loop_end})) begin
      next_position = loop_start;
      next_sample   = loop_start_sample;
    end else if (!looping && (p1_s >= {1'b0, sample_count})) begin
      next_position = position;
      next_sample   = decoded_s;
      next_playing  = 1'b0;
    end else begin
      next_position = p1_s[POS_W-1:0];
      next_sample   = decoded_s;
    end
    if (next_position == loop_start) begin
      next_loop_start_sample = next_sample;
    end else begin
      next_loop_start_sample = loop_start_sample;
    end
  end

endmodule

// File: rtl/audio_channel_bank.sv
// Time-multiplexed bank of delta-coded voices, mixed once per lrclk frame to stereo.
module audio_channel_bank
  import audio_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int SAMPLE_W     = 16,
  parameter int DELTA_W      = 12,
  parameter int POS_W        = 24,
  parameter int ADDR_W       = 32,
  parameter int VOL_W        = 8,
  localparam int CH_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [CH_W-1:0]            cfg_channel,
  input  logic [3:0]                 cfg_field,
  input  logic [POS_W-1:0]           cfg_data,
  input  logic                       lrclk,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic                       mem_ack,
  input  logic signed [DELTA_W-1:0]  mem_delta,
  output logic signed [SAMPLE_W-1:0] o_left,
  output logic signed [SAMPLE_W-1:0] o_right,
  output logic                       o_valid,
  output logic [NUM_CHANNELS-1:0]    o_playing,
  output logic                       o_overrun
);

  localparam int ACC_W  = SAMPLE_W + $clog2(NUM_CHANNELS) + 1;
  localparam int PROD_W = SAMPLE_W + VOL_W + 1;
  localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NUM_CHANNELS - 1);

  bank_state_t state_r, state_n;
  logic lrclk_q_r;
  logic frame_start_s;
  logic [CH_W-1:0] idx_r;
  logic signed [DELTA_W-1:0] delta_r;
  logic signed [ACC_W-1:0] acc_l_r, acc_r_r;

  logic [POS_W-1:0]           start_addr_r        [NUM_CHANNELS];
  logic [POS_W-1:0]           sample_count_r      [NUM_CHANNELS];
  logic [POS_W-1:0]           loop_start_r        [NUM_CHANNELS];
  logic [POS_W-1:0]           loop_end_r          [NUM_CHANNELS];
  logic [POS_W-1:0]           position_r          [NUM_CHANNELS];
  logic signed [SAMPLE_W-1:0] last_sample_r       [NUM_CHANNELS];
  logic signed [SAMPLE_W-1:0] loop_start_sample_r [NUM_CHANNELS];
  logic [VOL_W-1:0]           volume_r            [NUM_CHANNELS];
  logic [1:0]                 route_r             [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]    looping_r;
  logic [NUM_CHANNELS-1:0]    playing_r;

  logic signed [SAMPLE_W-1:0] dec_sample_s, dec_lss_s, vol_s;
  logic [POS_W-1:0]           dec_position_s;
  logic                       dec_playing_s;
  logic signed [PROD_W-1:0]   mul_a_s, mul_b_s, prod_s, scaled_s;
  logic signed [63:0]         vol_wide_s, sat_l_wide_s, sat_r_wide_s;
  logic signed [ACC_W-1:0]    vol_ext_s;
  logic [ADDR_W-1:0]          fetch_addr_s;

  assign frame_start_s = lrclk & ~lrclk_q_r;
  assign o_playing     = playing_r;

  // One decoder shared by all voices, fed by the voice currently selected by idx_r.
  delta_decoder #(.SAMPLE_W(SAMPLE_W), .DELTA_W(DELTA_W), .POS_W(POS_W)) u_decoder (
    .last_sample            (last_sample_r[idx_r]),
    .delta                  (delta_r),
    .position               (position_r[idx_r]),
    .sample_count           (sample_count_r[idx_r]),
    .loop_start             (loop_start_r[idx_r]),
    .loop_end               (loop_end_r[idx_r]),
    .loop_start_sample      (loop_start_sample_r[idx_r]),
    .looping                (looping_r[idx_r]),
    .playing                (playing_r[idx_r]),
    .next_sample            (dec_sample_s),
    .next_position          (dec_position_s),
    .next_playing           (dec_playing_s),
    .next_loop_start_sample (dec_lss_s)
  );

  // Volume scaling (128 = unity) and sign extension into the accumulator width.
  always_comb begin
    mul_a_s    = {{(VOL_W+1){dec_sample_s[SAMPLE_W-1]}}, dec_sample_s};
    mul_b_s    = {{SAMPLE_W{1'b0}}, 1'b0, volume_r[idx_r]};
    prod_s     = mul_a_s * mul_b_s;
    scaled_s   = prod_s >>> (VOL_W - 1);
    vol_wide_s = sat_s({{(64-PROD_W){scaled_s[PROD_W-1]}}, scaled_s}, SAMPLE_W);
    vol_s      = vol_wide_s[SAMPLE_W-1:0];
    vol_ext_s  = {{(ACC_W-SAMPLE_W){vol_s[SAMPLE_W-1]}}, vol_s};
  end

  // Final clamp of the wide accumulators and the fetch address of the current voice.
  always_comb begin
    sat_l_wide_s = sat_s({{(64-ACC_W){acc_l_r[ACC_W-1]}}, acc_l_r}, SAMPLE_W);
    sat_r_wide_s = sat_s({{(64-ACC_W){acc_r_r[ACC_W-1]}}, acc_r_r}, SAMPLE_W);
    fetch_addr_s = ADDR_W'(start_addr_r[idx_r]) + ADDR_W'(position_r[idx_r])
                 + {{(ADDR_W-1){1'b0}}, 1'b1};
  end

  // Sweep state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Sweep next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE:   if (frame_start_s) state_n = ST_SCAN; else state_n = ST_IDLE;
      ST_SCAN:   if (playing_r[idx_r]) state_n = ST_FETCH; else state_n = ST_NEXT;
      ST_FETCH:  if (mem_ack) state_n = ST_UPDATE; else state_n = ST_FETCH;
      ST_UPDATE: state_n = ST_NEXT;
      ST_NEXT:   if (idx_r == LAST_IDX) state_n = ST_DONE; else state_n = ST_SCAN;
      ST_DONE:   state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // Memory request outputs, held stable for the whole fetch.
  always_comb begin
    if (state_r == ST_FETCH) begin
      mem_req  = 1'b1;
      mem_addr = fetch_addr_s;
    end else begin
      mem_req  = 1'b0;
      mem_addr = {ADDR_W{1'b0}};
    end
  end

  // Sweep datapath: voice index, delta capture, accumulation, mix output and overrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lrclk_q_r <= 1'b0;
      idx_r     <= {CH_W{1'b0}};
      delta_r   <= {DELTA_W{1'b0}};
      acc_l_r   <= {ACC_W{1'b0}};
      acc_r_r   <= {ACC_W{1'b0}};
      o_left    <= {SAMPLE_W{1'b0}};
      o_right   <= {SAMPLE_W{1'b0}};
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      lrclk_q_r <= lrclk;
      o_valid   <= 1'b0;
      if (frame_start_s && (state_r != ST_IDLE)) begin
        o_overrun <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (frame_start_s) begin
            idx_r   <= {CH_W{1'b0}};
            acc_l_r <= {ACC_W{1'b0}};
            acc_r_r <= {ACC_W{1'b0}};
          end
        end
        ST_FETCH: begin
          if (mem_ack) delta_r <= mem_delta;
        end
        ST_UPDATE: begin
          if (route_r[idx_r] != ROUTE_RIGHT) acc_l_r <= acc_l_r + vol_ext_s;
          if (route_r[idx_r] != ROUTE_LEFT)  acc_r_r <= acc_r_r + vol_ext_s;
        end
        ST_NEXT: begin
          if (idx_r != LAST_IDX) idx_r <= idx_r + {{(CH_W-1){1'b0}}, 1'b1};
        end
        ST_DONE: begin
          o_left  <= sat_l_wide_s[SAMPLE_W-1:0];
          o_right <= sat_r_wide_s[SAMPLE_W-1:0];
          o_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Per-voice state: decode results in UPDATE, overridden by a same-cycle config write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        start_addr_r[i]        <= {POS_W{1'b0}};
        sample_count_r[i]      <= {POS_W{1'b0}};
        loop_start_r[i]        <= {POS_W{1'b0}};
        loop_end_r[i]          <= {POS_W{1'b0}};
        position_r[i]          <= {POS_W{1'b0}};
        last_sample_r[i]       <= {SAMPLE_W{1'b0}};
        loop_start_sample_r[i] <= {SAMPLE_W{1'b0}};
        volume_r[i]            <= {VOL_W{1'b0}};
        route_r[i]             <= ROUTE_BOTH;
      end
      looping_r <= {NUM_CHANNELS{1'b0}};
      playing_r <= {NUM_CHANNELS{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if ((state_r == ST_UPDATE) && (idx_r == CH_W'(i))) begin
          position_r[i]          <= dec_position_s;
          last_sample_r[i]       <= dec_sample_s;
          loop_start_sample_r[i] <= dec_lss_s;
          playing_r[i]           <= dec_playing_s;
        end
        if (cfg_we && (cfg_channel == CH_W'(i))) begin
          case (cfg_field)
            START_ADDR:   start_addr_r[i]   <= cfg_data;
            SAMPLE_COUNT: sample_count_r[i] <= cfg_data;
            LOOP_START:   loop_start_r[i]   <= cfg_data;
            LOOP_END:     loop_end_r[i]     <= cfg_data;
            POSITION:     position_r[i]     <= cfg_data;
            LAST_SAMPLE:  last_sample_r[i]  <= cfg_data[SAMPLE_W-1:0];
            VOLUME:       volume_r[i]       <= cfg_data[VOL_W-1:0];
            LOOPING:      looping_r[i]      <= cfg_data[0];
            PLAYING:      playing_r[i]      <= cfg_data[0];
            ROUTE:        route_r[i]        <= cfg_data[1:0];
            default: ;
          endcase
        end
      end
    end
  end

endmodule
